// File: rtl/rx_iq_spi_buffer.sv
// I/Q sample FIFO drained by an SPI slave, one 48-bit {I,Q} frame per chip-select.
// SPI pins are oversampled in the receiver clock domain; the head entry pops only after a complete frame.
module rx_iq_spi_buffer #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_strobe,
    input  logic [23:0]   in_I,
    input  logic [23:0]   in_Q,
    input  logic          spi_sck,
    input  logic          spi_ce_n,
    output logic          spi_miso,
    output logic          data_ready,
    output logic [LW-1:0] fifo_level,
    output logic [7:0]    overflow_count
);
    localparam int AW = LW - 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sck_q, ce_q;
    logic [47:0]     mem [DEPTH];
    logic [47:0]     shift_q, shift_d;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic            fv_q, fv_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   count_q, count_d;
    logic            ready_q;
    logic [7:0]      ovf_q, ovf_d;
    logic            sck_rise, sck_fall, ce_fall, ce_rise;
    logic            full, push, drop, pop;

    // Stage [2] is the edge-detect reference behind the 2-FF synchroniser.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ce_fall  = ~ce_q[1] & ce_q[2];
    assign ce_rise  = ce_q[1] & ~ce_q[2];

    assign full = (count_q == LW'(DEPTH));
    assign push = in_strobe & ~full;
    assign drop = in_strobe & full;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        fv_d     = fv_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: if (ce_fall) state_d = LOAD;
            LOAD: begin
                // Head is only peeked here; it leaves the FIFO once the frame completes.
                if (count_q != '0) begin
                    shift_d = mem[rptr_q];
                    fv_d    = 1'b1;
                end else begin
                    shift_d = '0;
                    fv_d    = 1'b0;
                end
                bitcnt_d = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (sck_rise && bitcnt_q != 6'd48) bitcnt_d = bitcnt_q + 6'd1;
                if (sck_fall) shift_d = {shift_q[46:0], 1'b0};
                if (ce_rise) state_d = FINISH;
            end
            FINISH: begin
                pop     = fv_q & (bitcnt_q == 6'd48);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_d = count_q + LW'(push) - LW'(pop);
    assign ovf_d   = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sck_q    <= 3'b000;
            ce_q     <= 3'b111;
            shift_q  <= '0;
            bitcnt_q <= '0;
            fv_q     <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            sck_q    <= {sck_q[1:0], spi_sck};
            ce_q     <= {ce_q[1:0], spi_ce_n};
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            fv_q     <= fv_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q  <= count_d;
            ready_q  <= (count_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) mem[wptr_q] <= {in_I, in_Q};
    end

    assign spi_miso       = (state_q == SHIFT || state_q == FINISH) ? shift_q[47] : 1'b0;
    assign data_ready     = ready_q;
    assign fifo_level     = count_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_rx_iq_spi_buffer.sv
// Bench for rx_iq_spi_buffer: vector table, hand-timed corner sequences and a queue-based reference model.
module tb_rx_iq_spi_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_strobe = 1'b0;
    logic [23:0] in_I = '0, in_Q = '0;
    logic        spi_sck = 1'b0;
    logic        spi_ce_n = 1'b1;
    logic        spi_miso, data_ready;
    logic [4:0]  fifo_level;
    logic [7:0]  overflow_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] q_m[$];
    int          ovf_m = 0;

    rx_iq_spi_buffer #(.DEPTH(16), .LW(5)) dut (
        .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_I(in_I), .in_Q(in_Q),
        .spi_sck(spi_sck), .spi_ce_n(spi_ce_n), .spi_miso(spi_miso),
        .data_ready(data_ready), .fifo_level(fifo_level), .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          push;
        logic [23:0] i;
        logic [23:0] q;
        int          pulses;
        logic [63:0] exp_rx;
        int          exp_level;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        check({name, " level"}, 64'(fifo_level), 64'(q_m.size()));
        check({name, " ready"}, 64'(data_ready), 64'(q_m.size() != 0));
        check({name, " ovf"}, 64'(overflow_count), 64'(ovf_m));
    endtask

    // Drives one strobe and applies the same push/drop rule to the model queue.
    task automatic do_push(input logic [23:0] i, input logic [23:0] q);
        in_strobe = 1'b1; in_I = i; in_Q = q;
        if (q_m.size() < 16) q_m.push_back({i, q});
        else if (ovf_m < 255) ovf_m++;
        tick(1);
        in_strobe = 1'b0;
    endtask

    task automatic model_frame(input int n, output logic [63:0] exp);
        logic [63:0] d;
        d = (q_m.size() != 0) ? {16'h0, q_m[0]} : 64'h0;
        exp = (n <= 48) ? (d >> (48 - n)) : (d << (n - 48));
        if (n >= 48 && q_m.size() != 0) void'(q_m.pop_front());
    endtask

    // Mode-0 master: bit sampled just before each rising sck, half-period 7 clocks.
    task automatic frame_body(input int n, output logic [63:0] rx);
        rx = '0;
        spi_ce_n = 1'b0;
        tick(6);
        for (int b = 0; b < n; b++) begin
            rx = {rx[62:0], spi_miso};
            spi_sck = 1'b1; tick(7);
            spi_sck = 1'b0; tick(7);
        end
    endtask

    task automatic frame(input int n, output logic [63:0] rx);
        frame_body(n, rx);
        spi_ce_n = 1'b1;
        tick(10);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [63:0] rx, exp;
        logic [47:0] sent[$];
        int          got, lvl;

        vecs[0] = '{1'b1, 24'h123456, 24'hABCDEF, 48, 64'h123456ABCDEF, 0};
        vecs[1] = '{1'b0, 24'h0, 24'h0, 48, 64'h0, 0};
        vecs[2] = '{1'b1, 24'h111111, 24'h222222, 0, 64'h0, 1};
        vecs[3] = '{1'b1, 24'h333333, 24'h444444, 20, 64'h11111, 2};
        vecs[4] = '{1'b0, 24'h0, 24'h0, 48, 64'h111111222222, 1};
        vecs[5] = '{1'b0, 24'h0, 24'h0, 48, 64'h333333444444, 0};
        vecs[6] = '{1'b1, 24'h800001, 24'h7FFFFE, 60, 64'h8000017FFFFE000, 0};
        vecs[7] = '{1'b0, 24'h0, 24'h0, 48, 64'h0, 0};

        tick(3);
        check("reset miso", 64'(spi_miso), 64'h0);
        check_state("reset");
        reset = 1'b0;
        tick(2);

        foreach (vecs[k]) begin
            if (vecs[k].push) begin
                lvl = q_m.size();
                do_push(vecs[k].i, vecs[k].q);
                check($sformatf("vec%0d push level", k), 64'(fifo_level), 64'(lvl + 1));
            end
            frame(vecs[k].pulses, rx);
            model_frame(vecs[k].pulses, exp);
            check($sformatf("vec%0d rx", k), rx, vecs[k].exp_rx);
            check($sformatf("vec%0d level", k), 64'(fifo_level), 64'(vecs[k].exp_level));
            check_state($sformatf("vec%0d", k));
        end

        // Full FIFO: 20 pushes, then a strobe landing on the FINISH cycle of a full frame.
        for (int k = 0; k < 20; k++) do_push(24'(k + 24'h100), 24'(k * 3 + 1));
        check_state("full");
        frame_body(48, rx);
        spi_ce_n = 1'b1;
        tick(3);
        do_push(24'hDEAD00, 24'hBEEF00);
        tick(2);
        model_frame(48, exp);
        check("full-finish rx", rx, exp);
        check_state("full-finish");
        for (int k = 0; k < 15; k++) begin
            frame(48, rx);
            model_frame(48, exp);
            check($sformatf("drain%0d rx", k), rx, exp);
        end
        check_state("drained");

        // Push while not full in the FINISH cycle: both take effect.
        do_push(24'hA0A0A0, 24'h0A0A0A);
        frame_body(48, rx);
        spi_ce_n = 1'b1;
        tick(3);
        do_push(24'hB1B1B1, 24'h1B1B1B);
        tick(2);
        model_frame(48, exp);
        check("finish-push rx", rx, exp);
        check_state("finish-push");
        frame(48, rx);
        model_frame(48, exp);
        check("finish-push next rx", rx, exp);

        // Randomized pushes and frames of assorted lengths against the queue model.
        for (int it = 0; it < 40; it++) begin
            int np, pl, sel;
            logic [31:0] r1, r2;
            np = (it % 10 == 9) ? 12 : $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                r1 = $urandom; r2 = $urandom;
                do_push(r1[23:0], r2[23:0]);
            end
            sel = $urandom_range(0, 6);
            case (sel)
                0: pl = 0;  1: pl = 20; 2: pl = 47;
                3: pl = 48; 4: pl = 48; 5: pl = 49;
                default: pl = 56;
            endcase
            frame(pl, rx);
            model_frame(pl, exp);
            check($sformatf("rand%0d rx n=%0d", it, pl), rx, exp);
            check_state($sformatf("rand%0d", it));
        end
        while (q_m.size() != 0) begin
            frame(48, rx);
            model_frame(48, exp);
            check("rand drain rx", rx, exp);
        end

        // Concurrent traffic: strobes every 1280 cycles under back-to-back frames.
        got = 0;
        fork
            begin
                logic [31:0] r;
                for (int k = 0; k < 32; k++) begin
                    tick(1280);
                    r = $urandom;
                    in_strobe = 1'b1; in_I = r[23:0]; in_Q = {r[31:24], 8'h00, 8'(k + 1)};
                    sent.push_back({in_I, in_Q});
                    tick(1);
                    in_strobe = 1'b0;
                end
            end
            begin
                for (int f = 0; f < 120 && got < 32; f++) begin
                    frame(48, rx);
                    if (rx != 64'h0) begin
                        if (got < sent.size()) check($sformatf("conc sample%0d", got), rx, 64'(sent[got]));
                        else check("conc unexpected", rx, 64'h0);
                        got++;
                    end
                end
            end
        join
        check("conc count", 64'(got), 64'd32);
        check_state("conc end");

        // Overflow count saturates at 255.
        for (int k = 0; k < 16 + 260; k++) do_push(24'(k), 24'h5A5A5A);
        check_state("saturate");

        reset = 1'b1; tick(1); reset = 1'b0;
        q_m.delete(); ovf_m = 0;
        tick(2);
        check_state("reset2");

        // Reset mid-frame with three samples stored.
        for (int k = 0; k < 3; k++) do_push(24'hFFFFFF, 24'hFFFFF0 + 24'(k));
        frame_body(10, rx);
        check("preset miso", 64'(spi_miso), 64'h1);
        reset = 1'b1;
        #1;
        q_m.delete(); ovf_m = 0;
        check("midreset miso", 64'(spi_miso), 64'h0);
        check_state("midreset");
        spi_ce_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        frame(48, rx);
        check("post-reset rx", rx, 64'h0);
        check_state("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
